keyboard_controller: RTL and testbench

- Debounces and samples a parallel 8-bit key code bus from a matrix/keypad front end.
- Emits a one-cycle `keyReady` strobe with the captured code in `savedByte` once the code has been stable for a programmable number of divided sample ticks.
- Reports each stable code exactly once; sits between raw keyboard inputs and the byte consumer (typing/game logic).

---
 rtl/keyboard_pkg.sv | 16 +
 rtl/keyboard_controller_tick_gen.sv | 35 +++
 rtl/keyboard_controller.sv | 110 +++++++++++
 tb/tb_keyboard_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared types and default constants for the keyboard controller.
// Optional build macro used by keyboard_controller: KEYBOARD_CONTROLLER_IGNORE_ZERO_EN.
package keyboard_pkg;

    // Width of the parallel key code bus.
    localparam int KEY_W = 8;

    // One key code as seen on the keypad front end.
    typedef logic [KEY_W-1:0] key_t;

    // Default timing: system clocks per sample tick, and how many
    // consecutive equal ticks make a code "stable".
    localparam int DEF_CLOCKDIVISOR         = 1000;
    localparam int DEF_STEADYCOUNTTHRESHOLD = 7;

endpackage : keyboard_pkg

// File: rtl/keyboard_controller_tick_gen.sv
// Sample-tick divider: free-running counter 0..DIVISOR-1 that raises
// tick for exactly one clk while it sits on its last value.
module tick_gen #(
    parameter int DIVISOR = 1000,
    parameter int CNT_W   = $clog2(DIVISOR)
) (
    input  logic clk,
    input  logic RST,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_end;

    // Next counter value: wrap to zero after the last count.
    always_comb begin
        at_end = (cnt_q == CNT_W'(DIVISOR - 1));
        cnt_d  = at_end ? '0 : cnt_q + 1'b1;
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Tick is decoded straight from the registered count, so it is a
    // clean single-cycle strobe aligned with the counter wrap.
    assign tick = at_end;

endmodule : tick_gen

// File: rtl/keyboard_controller.sv
// Keyboard controller: samples the raw key code on divider ticks, waits
// until it has been equal for STEADYCOUNTTHRESHOLD further ticks and then
// reports it once through savedByte / keyReady.
// Optional build macro: KEYBOARD_CONTROLLER_IGNORE_ZERO_EN -- when defined,
// a stable 8'h00 ("no key") is tracked but never reported.
module keyboard_controller
    import keyboard_pkg::*;
#(
    parameter int CLOCKDIVISOR         = DEF_CLOCKDIVISOR,
    parameter int STEADYCOUNTTHRESHOLD = DEF_STEADYCOUNTTHRESHOLD
) (
    input  logic clk,
    input  logic RST,
    input  key_t keyValues,
    output key_t savedByte,
    output logic keyReady
);

    // Divider width follows directly from the divisor.
    localparam int CLOCKDIVIDERWIDTH = $clog2(CLOCKDIVISOR);

    // The steady counter must be able to hold the threshold itself.
    localparam int STEADY_W = $clog2(STEADYCOUNTTHRESHOLD + 1);
    localparam logic [STEADY_W-1:0] STEADY_MAX = STEADY_W'(STEADYCOUNTTHRESHOLD);

    logic tick;

    // Tracking state.
    key_t                last_q,     last_d;
    logic [STEADY_W-1:0] steady_q,   steady_d;
    logic                reported_q, reported_d;

    // Output registers.
    key_t saved_q, saved_d;
    logic ready_q, ready_d;

    // Whether the code currently being tracked may be reported at all.
    logic report_allowed;

    tick_gen #(
        .DIVISOR (CLOCKDIVISOR),
        .CNT_W   (CLOCKDIVIDERWIDTH)
    ) u_tick_gen (
        .clk  (clk),
        .RST  (RST),
        .tick (tick)
    );

`ifdef KEYBOARD_CONTROLLER_IGNORE_ZERO_EN
    // "No key" is tracked like any code but never reaches the consumer.
    assign report_allowed = (last_q != '0);
`else
    // Every code, including 8'h00, is reported.
    assign report_allowed = 1'b1;
`endif

    // Per-tick compare / stability counting and the single report strobe.
    always_comb begin
        last_d     = last_q;
        steady_d   = steady_q;
        reported_d = reported_q;
        saved_d    = saved_q;
        ready_d    = 1'b0;

        if (tick) begin
            if (keyValues != last_q) begin
                // A new code restarts the stability window.
                last_d     = keyValues;
                steady_d   = '0;
                reported_d = 1'b0;
            end else begin
                // Same code again: count up, saturating at the threshold
                // so a held key cannot wrap around and re-report.
                if (steady_q < STEADY_MAX) begin
                    steady_d = steady_q + 1'b1;
                end
                // Report once per stable run; reported blocks repeats
                // until a different code is sampled.
                if ((steady_d == STEADY_MAX) && !reported_q) begin
                    reported_d = 1'b1;
                    if (report_allowed) begin
                        saved_d = last_q;
                        ready_d = 1'b1;
                    end
                end
            end
        end
    end

    // State and output registers; reset drops any pending report.
    always_ff @(posedge clk) begin
        if (RST) begin
            last_q     <= '0;
            steady_q   <= '0;
            reported_q <= 1'b0;
            saved_q    <= '0;
            ready_q    <= 1'b0;
        end else begin
            last_q     <= last_d;
            steady_q   <= steady_d;
            reported_q <= reported_d;
            saved_q    <= saved_d;
            ready_q    <= ready_d;
        end
    end

    assign savedByte = saved_q;
    assign keyReady  = ready_q;

endmodule : keyboard_controller

// File: tb/tb_keyboard_controller.sv
// Testbench for keyboard_controller (divisor 10, threshold 7): directed
// steps from the test plan followed by randomized key holds, all checked
// against a run-length reference model of the tick-time samples.
module tb_keyboard_controller;
    import keyboard_pkg::*;

    localparam int DIV = 10;
    localparam int THR = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic RST = 1'b0;
    key_t keyValues = '0;
    key_t savedByte;
    logic keyReady;

    always #5 clk = ~clk;

    keyboard_controller #(
        .CLOCKDIVISOR         (DIV),
        .STEADYCOUNTTHRESHOLD (THR)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .keyValues (keyValues),
        .savedByte (savedByte),
        .keyReady  (keyReady)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int pulse_cnt      = 0;
    int last_pulse_cyc = -1;
    int change_cyc     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Ticks fall on every DIV-th clk edge after the reset edge. The sampled
    // codes form runs; reset behaves as a run of 8'h00 of length one. A run
    // that reaches THR+1 equal samples is reported exactly once.
    logic       model_on  = 1'b0;
    int         edge_n    = 0;
    key_t       run_val   = '0;
    int         run_len   = 1;
    logic       exp_ready = 1'b0;
    key_t       exp_saved = '0;
    logic [7:0] exp_q[$];

    function automatic logic reportable(input key_t v);
`ifdef KEYBOARD_CONTROLLER_IGNORE_ZERO_EN
        return (v != 8'h00);
`else
        return 1'b1;
`endif
    endfunction

    always @(posedge clk) begin
        if (RST) begin
            model_on  = 1'b1;
            edge_n    = 0;
            run_val   = '0;
            run_len   = 1;
            exp_ready = 1'b0;
            exp_saved = '0;
            exp_q.delete();
        end else if (model_on) begin
            edge_n++;
            exp_ready = 1'b0;
            if (edge_n % DIV == 0) begin
                if (keyValues == run_val) begin
                    run_len++;
                end else begin
                    run_val = keyValues;
                    run_len = 1;
                end
                if (run_len == THR + 1 && reportable(run_val)) begin
                    exp_ready = 1'b1;
                    exp_saved = run_val;
                    exp_q.push_back(run_val);
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (model_on) begin
            check("keyReady", {31'd0, keyReady}, {31'd0, exp_ready});
            check("savedByte", {24'd0, savedByte}, {24'd0, exp_saved});
            if (keyReady === 1'b1) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
                check("pulse_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
                if (exp_q.size() > 0) begin
                    check("pulse_code", {24'd0, savedByte}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driving happens 1 time unit after a rising edge.
    task automatic do_reset();
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0;
    endtask

    task automatic hold(input key_t v, input int n);
        keyValues  = v;
        change_cyc = cyc;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string tag);
        int lat;
        lat = last_pulse_cyc - change_cyc;
        check(tag, {31'd0, (lat >= THR * DIV + 1 && lat <= (THR + 1) * DIV)}, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   p0;
        int   c_hold;
        key_t v;

        @(posedge clk);
        #1;
        do_reset();
        check("reset_saved", {24'd0, savedByte}, 32'h00);
        check("reset_ready", {31'd0, keyReady}, 32'd0);

        // Stable 8'h48: one pulse within the latency window.
        p0 = pulse_cnt;
        hold(8'h48, 90);
        check("h48_pulses", pulse_cnt - p0, 32'd1);
        check_latency("h48_latency");
        check("h48_saved", {24'd0, savedByte}, 32'h48);

        // 8'h45 for 69 cycles is too short to report.
        p0 = pulse_cnt;
        hold(8'h45, 69);
        check("h45_no_pulse", pulse_cnt - p0, 32'd0);
        check("h45_saved_kept", {24'd0, savedByte}, 32'h48);

        // 8'h4C held 80 cycles: one pulse within the window.
        p0 = pulse_cnt;
        hold(8'h4C, 80);
        check("h4c_pulses", pulse_cnt - p0, 32'd1);
        check_latency("h4c_latency");
        check("h4c_saved", {24'd0, savedByte}, 32'h4C);

        // 8'h4F held 160 cycles: exactly one pulse, no repeat.
        p0 = pulse_cnt;
        hold(8'h4F, 160);
        check("h4f_pulses", pulse_cnt - p0, 32'd1);
        check("h4f_saved", {24'd0, savedByte}, 32'h4F);

        // Reset 5 cycles before the pulse would fire: pulse is aborted.
        do_reset();
        p0 = pulse_cnt;
        hold(8'h33, 75);
        do_reset();
        check("abort_saved", {24'd0, savedByte}, 32'h00);
        check("abort_ready", {31'd0, keyReady}, 32'd0);
        hold(8'h33, 10);
        check("abort_no_pulse", pulse_cnt - p0, 32'd0);

        // Zero held after reset.
        do_reset();
        p0 = pulse_cnt;
        hold(8'h00, 100);
`ifdef KEYBOARD_CONTROLLER_IGNORE_ZERO_EN
        check("zero_pulses", pulse_cnt - p0, 32'd0);
`else
        check("zero_pulses", pulse_cnt - p0, 32'd1);
`endif
        check("zero_saved", {24'd0, savedByte}, 32'h00);

        // Same code reported again after an intermediate code.
        p0 = pulse_cnt;
        hold(8'h21, 80);
        hold(8'h22, 25);
        hold(8'h21, 80);
        check("repeat_after_change", pulse_cnt - p0, 32'd2);
        check("repeat_saved", {24'd0, savedByte}, 32'h21);

        // Randomized holds including short glitches and occasional resets.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       v = 8'h00;
                1:       v = 8'h5A;
                default: v = key_t'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                c_hold = $urandom_range(1, 4);
            end else begin
                c_hold = $urandom_range(20, 120);
            end
            hold(v, c_hold);
            if ($urandom_range(0, 15) == 0) begin
                do_reset();
            end
        end
        hold(keyValues, 3 * DIV);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule : tb_keyboard_controller
